// File: rtl/mqnic_rx_queue_map_pkg.sv
// Shared definitions for the RX queue-map indirection table fill sequencer.
//
// Contents:
//   RESP_OKAY       - AXI-lite OKAY response code
//   AXIL_PROT_DATA  - protection bits used for table accesses
//   fill_state_t    - sequencer state encoding
//   tbl_entry_addr  - byte address of one table entry

package mqnic_rx_queue_map_pkg;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [2:0] AXIL_PROT_DATA = 3'b010;

  // ST_ADV is the advance step between entries; it is where the index and
  // offset counters move on and where the last entry is detected.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WAIT_B,
    ST_RD,
    ST_WAIT_R,
    ST_ADV,
    ST_DONE
  } fill_state_t;

  // Each port owns 2**tbl_addr_width consecutive 32-bit entries.
  function automatic logic [63:0] tbl_entry_addr(
    input logic [63:0] base,
    input logic [31:0] port,
    input logic [31:0] idx,
    input int unsigned tbl_addr_width
  );
    return base + (((64'(port) << tbl_addr_width) + 64'(idx)) << 2);
  endfunction

endpackage

// File: rtl/mqnic_rr_index_gen.sv
// Round-robin index generator for the indirection table fill.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - restart both counters at zero (new command)
//   advance      - step to the next table entry
//   queue_count  - number of queues in the spread (nonzero while in use)
//   idx          - current table entry index
//   off          - current queue offset, always < queue_count
//   last         - idx is the final entry of the table

module mqnic_rr_index_gen
  import mqnic_rx_queue_map_pkg::*;
#(
  parameter int IDX_WIDTH   = 8,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [COUNT_WIDTH-1:0] queue_count,
  output logic [IDX_WIDTH-1:0]   idx,
  output logic [COUNT_WIDTH-1:0] off,
  output logic                   last
);

  // One extra bit so the increment can never alias back onto queue_count.
  logic [COUNT_WIDTH:0] off_inc;
  logic                 off_wrap;

  assign off_inc  = {1'b0, off} + (COUNT_WIDTH+1)'(1);
  assign off_wrap = (off_inc == {1'b0, queue_count});
  assign last     = &idx;

  // The modulo is a compare-and-wrap: off only ever grows by one, so it wraps
  // exactly when it reaches queue_count. A count larger than the table simply
  // never triggers the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      off <= '0;
    end else if (clear) begin
      idx <= '0;
      off <= '0;
    end else if (advance) begin
      idx <= idx + IDX_WIDTH'(1);
      off <= off_wrap ? '0 : off_inc[COUNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mqnic_rx_indir_tbl_fill.sv
// Indirection table fill sequencer: programs one port's RX queue-map table
// over AXI-lite with entry i = base_queue + (i mod queue_count), optionally
// reading every entry back to confirm it.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   cmd_*             - fill command (port, base queue, count, verify, function id)
//   cmd_valid/ready   - command handshake, ready only while idle
//   sts_done/error    - completion pulse and failure flag
//   sts_busy          - command in progress
//   m_axil_*          - AXI-lite master towards the queue-map table slave

module mqnic_rx_indir_tbl_fill
  import mqnic_rx_queue_map_pkg::*;
#(
  parameter int PORTS                = 1,
  parameter int QUEUE_INDEX_WIDTH    = 10,
  parameter int INDIR_TBL_ADDR_WIDTH = 8,
  parameter int AXIL_DATA_WIDTH      = 32,
  parameter int AXIL_ADDR_WIDTH      = $clog2(PORTS) + INDIR_TBL_ADDR_WIDTH + 2,
  parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR = '0,
  parameter int FUNCTION_ID_WIDTH    = 8,
  parameter int PORT_WIDTH           = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic [PORT_WIDTH-1:0]          cmd_port,
  input  logic [QUEUE_INDEX_WIDTH-1:0]   cmd_base_queue,
  input  logic [QUEUE_INDEX_WIDTH:0]     cmd_queue_count,
  input  logic                           cmd_verify,
  input  logic [FUNCTION_ID_WIDTH-1:0]   cmd_function_id,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,

  output logic                           sts_done,
  output logic                           sts_error,
  output logic                           sts_busy,

  output logic [AXIL_ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic [FUNCTION_ID_WIDTH-1:0]   m_axil_awuser,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]     m_axil_araddr,
  output logic [FUNCTION_ID_WIDTH-1:0]   m_axil_aruser,
  output logic [2:0]                     m_axil_arprot,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready
);

  localparam int COUNT_WIDTH = QUEUE_INDEX_WIDTH + 1;

  fill_state_t state, state_next;

  logic [PORT_WIDTH-1:0]           port_q;
  logic [QUEUE_INDEX_WIDTH-1:0]    base_q;
  logic [COUNT_WIDTH-1:0]          count_q;
  logic                            verify_q;
  logic [FUNCTION_ID_WIDTH-1:0]    func_q;
  logic                            err_q, err_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            arvalid_q, arvalid_d;
  logic                            start, advance;

  logic [INDIR_TBL_ADDR_WIDTH-1:0] idx;
  logic [COUNT_WIDTH-1:0]          off;
  logic                            last;
  logic [QUEUE_INDEX_WIDTH-1:0]    wr_value;
  logic [AXIL_ADDR_WIDTH-1:0]      entry_addr;
  logic                            unused_rdata_hi;

  mqnic_rr_index_gen #(
    .IDX_WIDTH   (INDIR_TBL_ADDR_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_index_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start),
    .advance     (advance),
    .queue_count (count_q),
    .idx         (idx),
    .off         (off),
    .last        (last)
  );

  // Value and address are derived from the counters, which only move in the
  // advance step, so both are stable for the whole write/read of an entry.
  // The sum is taken wide and truncated, which gives the mod-2**width wrap.
  assign wr_value   = QUEUE_INDEX_WIDTH'({1'b0, base_q} + off);
  assign entry_addr = AXIL_ADDR_WIDTH'(tbl_entry_addr(64'(AXIL_BASE_ADDR), 32'(port_q),
                                                      32'(idx), INDIR_TBL_ADDR_WIDTH));

  assign unused_rdata_hi = ^m_axil_rdata[AXIL_DATA_WIDTH-1:QUEUE_INDEX_WIDTH];

  assign m_axil_awaddr  = entry_addr;
  assign m_axil_araddr  = entry_addr;
  assign m_axil_awuser  = func_q;
  assign m_axil_aruser  = func_q;
  assign m_axil_awprot  = AXIL_PROT_DATA;
  assign m_axil_arprot  = AXIL_PROT_DATA;
  assign m_axil_wdata   = AXIL_DATA_WIDTH'(wr_value);
  assign m_axil_wstrb   = '1;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_arvalid = arvalid_q;

  // State and channel valids. Reset drops every valid immediately, which
  // abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state     <= state_next;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end

  // Command fields are captured once at accept and held for the whole fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q   <= '0;
      base_q   <= '0;
      count_q  <= '0;
      verify_q <= 1'b0;
      func_q   <= '0;
    end else if (start) begin
      port_q   <= cmd_port;
      base_q   <= cmd_base_queue;
      count_q  <= cmd_queue_count;
      verify_q <= cmd_verify;
      func_q   <= cmd_function_id;
    end
  end

  // Next state, channel valids and status. In WR the aw and w channels are
  // tracked independently through their own valid: a dropped valid means that
  // channel has completed, so either may finish first.
  always_comb begin
    state_next    = state;
    err_d         = err_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    start         = 1'b0;
    advance       = 1'b0;
    cmd_ready     = (state == ST_IDLE);
    sts_busy      = (state != ST_IDLE);
    sts_done      = (state == ST_DONE);
    sts_error     = (state == ST_DONE) && err_q;
    m_axil_bready = (state == ST_WAIT_B);
    m_axil_rready = (state == ST_WAIT_R);

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          start = 1'b1;
          err_d = 1'b0;
          if (cmd_queue_count == '0 || 32'(cmd_port) >= 32'(PORTS)) begin
            err_d      = 1'b1;
            state_next = ST_DONE;
          end else begin
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            state_next = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)     state_next = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (m_axil_bvalid) begin
          if (m_axil_bresp != RESP_OKAY) begin
            err_d      = 1'b1;
            state_next = ST_DONE;
          end else if (verify_q) begin
            arvalid_d  = 1'b1;
            state_next = ST_RD;
          end else begin
            state_next = ST_ADV;
          end
        end
      end
      ST_RD: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d  = 1'b0;
          state_next = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (m_axil_rvalid) begin
          if (m_axil_rresp != RESP_OKAY ||
              m_axil_rdata[QUEUE_INDEX_WIDTH-1:0] != wr_value) begin
            err_d      = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_ADV;
          end
        end
      end
      ST_ADV: begin
        if (last) begin
          state_next = ST_DONE;
        end else begin
          advance    = 1'b1;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          state_next = ST_WR;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mqnic_rx_indir_tbl_fill.sv
// Self-checking bench for mqnic_rx_indir_tbl_fill with a small AXI-lite
// table slave and a reference model of the round-robin fill.

module tb_mqnic_rx_indir_tbl_fill;

  localparam int PORTS   = 2;
  localparam int QW      = 10;
  localparam int TAW     = 3;
  localparam int AW      = 6;
  localparam int DW      = 32;
  localparam int FW      = 8;
  localparam int ENTRIES = 1 << TAW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_port = 1'b0;
  logic [QW-1:0] cmd_base_queue = '0;
  logic [QW:0]   cmd_queue_count = '0;
  logic          cmd_verify = 1'b0;
  logic [FW-1:0] cmd_function_id = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready, sts_done, sts_error, sts_busy;

  logic [AW-1:0] awaddr, araddr;
  logic [FW-1:0] awuser, aruser;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic          bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0]   tbl [PORTS*ENTRIES];
  bit            aw_got, w_got, ar_got, b_retire, r_retire;
  logic [AW-1:0] aw_addr_l, ar_addr_l;
  logic [31:0]   w_data_l;
  int            aw_hs, w_hs, ar_hs, wr_count, err_on_write;
  int            aw_wait, w_wait, first_aw_cyc;
  bit            skew_mode, any_valid, attr_bad;
  logic [FW-1:0] cur_fid;
  logic [AW-1:0] log_addr [$];
  logic [31:0]   log_data [$];

  mqnic_rx_indir_tbl_fill #(
    .PORTS                (PORTS),
    .QUEUE_INDEX_WIDTH    (QW),
    .INDIR_TBL_ADDR_WIDTH (TAW),
    .AXIL_DATA_WIDTH      (DW),
    .AXIL_ADDR_WIDTH      (AW),
    .AXIL_BASE_ADDR       ('0),
    .FUNCTION_ID_WIDTH    (FW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_port        (cmd_port),
    .cmd_base_queue  (cmd_base_queue),
    .cmd_queue_count (cmd_queue_count),
    .cmd_verify      (cmd_verify),
    .cmd_function_id (cmd_function_id),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .sts_done        (sts_done),
    .sts_error       (sts_error),
    .sts_busy        (sts_busy),
    .m_axil_awaddr   (awaddr),
    .m_axil_awuser   (awuser),
    .m_axil_awprot   (awprot),
    .m_axil_awvalid  (awvalid),
    .m_axil_awready  (awready),
    .m_axil_wdata    (wdata),
    .m_axil_wstrb    (wstrb),
    .m_axil_wvalid   (wvalid),
    .m_axil_wready   (wready),
    .m_axil_bresp    (bresp),
    .m_axil_bvalid   (bvalid),
    .m_axil_bready   (bready),
    .m_axil_araddr   (araddr),
    .m_axil_aruser   (aruser),
    .m_axil_arprot   (arprot),
    .m_axil_arvalid  (arvalid),
    .m_axil_arready  (arready),
    .m_axil_rdata    (rdata),
    .m_axil_rresp    (rresp),
    .m_axil_rvalid   (rvalid),
    .m_axil_rready   (rready)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Table slave, acting on the falling edge so that every ready/valid it
  // drives is settled before the next rising edge. A handshake is recorded
  // when the slave raises ready against a valid it sees, since the DUT holds
  // valid until that rising edge. Responses go out one cycle after the
  // request handshake and are retired after bready/rready is seen.
  always @(negedge clk) begin
    if (awvalid || wvalid || arvalid) any_valid = 1'b1;
    if (awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      b_retire = 1'b0; r_retire = 1'b0; aw_wait = -1; w_wait = -1;
    end else begin
      if (b_retire) begin bvalid = 1'b0; b_retire = 1'b0; end
      if (r_retire) begin rvalid = 1'b0; r_retire = 1'b0; end
      if (aw_got && w_got && !bvalid) begin
        wr_count++;
        log_addr.push_back(aw_addr_l);
        log_data.push_back(w_data_l);
        tbl[int'(aw_addr_l >> 2)] = w_data_l;
        bresp  = (wr_count == err_on_write) ? 2'b10 : 2'b00;
        bvalid = 1'b1;
        aw_got = 1'b0;
        w_got  = 1'b0;
      end
      if (bvalid && bready) b_retire = 1'b1;
      if (ar_got && !rvalid) begin
        rdata  = tbl[int'(ar_addr_l >> 2)];
        rresp  = 2'b00;
        rvalid = 1'b1;
        ar_got = 1'b0;
      end
      if (rvalid && rready) r_retire = 1'b1;

      awready = 1'b0;
      if (awvalid && !aw_got) begin
        if (skew_mode) begin
          if (aw_wait < 0) aw_wait = $urandom_range(0, 5);
          if (aw_wait == 0) begin awready = 1'b1; aw_wait = -1; end
          else aw_wait--;
        end else awready = 1'b1;
        if (awready) begin
          aw_got = 1'b1; aw_addr_l = awaddr; aw_hs++;
          if (awprot !== 3'b010 || awuser !== cur_fid) attr_bad = 1'b1;
        end
      end
      wready = 1'b0;
      if (wvalid && !w_got) begin
        if (skew_mode) begin
          if (w_wait < 0) w_wait = $urandom_range(0, 5);
          if (w_wait == 0) begin wready = 1'b1; w_wait = -1; end
          else w_wait--;
        end else wready = 1'b1;
        if (wready) begin
          w_got = 1'b1; w_data_l = wdata; w_hs++;
          if (wstrb !== 4'hF) attr_bad = 1'b1;
        end
      end
      arready = 1'b0;
      if (arvalid && !ar_got) begin
        arready = 1'b1;
        ar_got = 1'b1; ar_addr_l = araddr; ar_hs++;
        if (arprot !== 3'b010 || aruser !== cur_fid || araddr !== aw_addr_l) attr_bad = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    log_addr.delete();
    log_data.delete();
    aw_hs = 0; w_hs = 0; ar_hs = 0; wr_count = 0;
    first_aw_cyc = -1; any_valid = 1'b0; attr_bad = 1'b0;
  endtask

  // Issue one command and wait (bounded) for its completion pulse.
  task automatic applyStimulus(input bit port, input int base, input int count, input bit verify,
                               output bit err, output int done_lat, output int aw_lat,
                               output bit busy_seen);
    int n;
    int accept_cyc;
    clearLogs();
    @(negedge clk);
    cur_fid         = FW'($urandom);
    cmd_port        = port;
    cmd_base_queue  = QW'(base);
    cmd_queue_count = (QW+1)'(count);
    cmd_verify      = verify;
    cmd_function_id = cur_fid;
    cmd_valid       = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    accept_cyc = cyc;
    busy_seen  = sts_busy;
    n = 0;
    while (!sts_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!sts_done) checkOutput("done_timeout", 64'(sts_done), 64'd1);
    err      = sts_error;
    done_lat = cyc - accept_cyc;
    aw_lat   = cyc - first_aw_cyc;
  endtask

  // Reference model: entry i of the port slice holds (base + i mod count)
  // mod 2**QW at byte address (port*ENTRIES + i)*4.
  task automatic checkFill(input string tag, input bit port, input int base, input int count,
                           input int nent, input bit verify);
    int m;
    checkOutput({tag, "_nwr"}, 64'(log_addr.size()), 64'(nent));
    checkOutput({tag, "_aw_hs"}, 64'(aw_hs), 64'(nent));
    checkOutput({tag, "_w_hs"}, 64'(w_hs), 64'(nent));
    checkOutput({tag, "_attr"}, 64'(attr_bad), 64'd0);
    if (verify) checkOutput({tag, "_ar_hs"}, 64'(ar_hs), 64'(nent));
    m = (log_addr.size() < nent) ? log_addr.size() : nent;
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("%s_addr[%0d]", tag, i), 64'(log_addr[i]),
                  64'((int'(port) * ENTRIES + i) * 4));
      checkOutput($sformatf("%s_data[%0d]", tag, i), 64'(log_data[i]),
                  64'((base + (i % count)) % (1 << QW)));
      if (verify)
        checkOutput($sformatf("%s_tbl[%0d]", tag, i),
                    64'(tbl[int'(port) * ENTRIES + i]),
                    64'((base + (i % count)) % (1 << QW)));
    end
  endtask

  initial begin
    bit err, busy;
    int dl, al, n;
    bit rp, rv;
    int rb, rc;

    err_on_write = 0;
    skew_mode    = 1'b0;
    clearLogs();
    for (int i = 0; i < PORTS*ENTRIES; i++) tbl[i] = 32'hDEAD_0000;

    repeat (3) @(negedge clk);
    checkOutput("reset_state",
                64'({awvalid, wvalid, arvalid, bready, rready, sts_done, sts_error, sts_busy, cmd_ready}),
                64'b000000001);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 64'(cmd_ready), 64'd1);

    $display("[TB] basic fill, zero-wait slave");
    applyStimulus(1'b1, 4, 3, 1'b0, err, dl, al, busy);
    checkOutput("basic_err", 64'(err), 64'd0);
    checkOutput("basic_busy", 64'(busy), 64'd1);
    checkOutput("basic_cycles", 64'(al), 64'd24);
    checkFill("basic", 1'b1, 4, 3, ENTRIES, 1'b0);
    @(negedge clk);
    checkOutput("basic_idle", 64'({sts_busy, sts_done, cmd_ready}), 64'b001);

    $display("[TB] fill with verify");
    applyStimulus(1'b1, 4, 3, 1'b1, err, dl, al, busy);
    checkOutput("verify_err", 64'(err), 64'd0);
    checkOutput("verify_cycles", 64'(al), 64'd40);
    checkFill("verify", 1'b1, 4, 3, ENTRIES, 1'b1);

    $display("[TB] zero queue count");
    applyStimulus(1'b0, 9, 0, 1'b1, err, dl, al, busy);
    checkOutput("zero_err", 64'(err), 64'd1);
    checkOutput("zero_lat_le2", 64'(dl <= 2), 64'd1);
    checkOutput("zero_no_axi", 64'(any_valid), 64'd0);

    $display("[TB] bresp error on third write");
    err_on_write = 3;
    applyStimulus(1'b0, 20, 5, 1'b0, err, dl, al, busy);
    checkOutput("berr_err", 64'(err), 64'd1);
    checkOutput("berr_nwr", 64'(wr_count), 64'd3);
    @(negedge clk);
    checkOutput("berr_ready_next", 64'(cmd_ready), 64'd1);
    err_on_write = 0;

    $display("[TB] boundary fills");
    applyStimulus(1'b0, 1022, 5, 1'b1, err, dl, al, busy);
    checkOutput("wrapq_err", 64'(err), 64'd0);
    checkFill("wrapq", 1'b0, 1022, 5, ENTRIES, 1'b1);
    applyStimulus(1'b1, 100, 20, 1'b0, err, dl, al, busy);
    checkOutput("bigcnt_err", 64'(err), 64'd0);
    checkFill("bigcnt", 1'b1, 100, 20, ENTRIES, 1'b0);
    applyStimulus(1'b0, 513, 1, 1'b0, err, dl, al, busy);
    checkFill("cnt1", 1'b0, 513, 1, ENTRIES, 1'b0);
    applyStimulus(1'b1, 7, 8, 1'b1, err, dl, al, busy);
    checkFill("cnt8", 1'b1, 7, 8, ENTRIES, 1'b1);

    $display("[TB] randomized commands with aw/w skew");
    skew_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      rp = 1'($urandom_range(0, 1));
      rb = $urandom_range(0, 1023);
      rc = $urandom_range(1, 12);
      rv = 1'($urandom_range(0, 1));
      applyStimulus(rp, rb, rc, rv, err, dl, al, busy);
      checkOutput($sformatf("rnd%0d_err", t), 64'(err), 64'd0);
      checkFill($sformatf("rnd%0d", t), rp, rb, rc, ENTRIES, rv);
    end

    $display("[TB] reset during write");
    clearLogs();
    @(negedge clk);
    cmd_port = 1'b0; cmd_base_queue = 10'd7; cmd_queue_count = 11'd2;
    cmd_verify = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(awvalid || wvalid) && n < 100) begin @(negedge clk); n++; end
    checkOutput("rst_reached_wr", 64'(awvalid || wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_state", 64'({awvalid, wvalid, arvalid, sts_busy, cmd_ready}), 64'b00001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    skew_mode = 1'b0;
    applyStimulus(1'b0, 30, 3, 1'b1, err, dl, al, busy);
    checkOutput("after_rst_err", 64'(err), 64'd0);
    checkFill("after_rst", 1'b0, 30, 3, ENTRIES, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
